mac_result_fifo: RTL and testbench

//   Downstream stage of the mac block. Captures each mac_out word flagged by out_valid

---
 rtl/mac_result_fifo.sv | 115 +++++++++++
 tb/tb_mac_result_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_fifo.sv
// First-word-fall-through result FIFO behind the mac block, with an accepted-result
// counter, a running unsigned maximum and a sticky overflow flag for dropped results.
`timescale 1ns/1ps
module mac_result_fifo #(
    parameter int DATA_W = 11,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          mac_out,
    input  logic                       out_valid,
    input  logic                       clr,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic [CNT_W-1:0]           res_count,
    output logic [DATA_W-1:0]          max_val
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  res_count_q, res_count_d;
    logic [DATA_W-1:0] max_val_q, max_val_d;

    logic clear, push, pop, drop;

    assign clear = reset | clr;

    // Status flags come only from registered occupancy, never from the inputs.
    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign rd_valid = ~empty;
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];

    assign pop  = rd_valid & rd_ready;
    assign push = out_valid & (~full | pop);
    assign drop = out_valid & full & ~pop;

    assign level     = level_q;
    assign overflow  = overflow_q;
    assign res_count = res_count_q;
    assign max_val   = max_val_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        res_count_d = res_count_q;
        max_val_d   = max_val_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end

        // Statistics only see words that actually entered the FIFO.
        if (push) begin
            if (res_count_q != '1) begin
                res_count_d = res_count_q + 1'b1;
            end
            if (mac_out > max_val_q) begin
                max_val_d = mac_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            res_count_q <= '0;
            max_val_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            res_count_q <= res_count_d;
            max_val_q   <= max_val_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= mac_out;
        end
    end

endmodule

// File: tb/tb_mac_result_fifo.sv
// Scoreboard bench for mac_result_fifo: directed scenarios followed by random traffic,
// checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_mac_result_fifo;

    localparam int DATA_W = 11;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 8;
    localparam int LVL_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] mac_out = '0;
    logic              out_valid = 1'b0;
    logic              clr = 1'b0;
    logic              rd_ready = 1'b0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              empty;
    logic              overflow;
    logic [CNT_W-1:0]  res_count;
    logic [DATA_W-1:0] max_val;

    always #5 clk = ~clk;

    mac_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .mac_out(mac_out), .out_valid(out_valid),
        .clr(clr), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .level(level), .full(full), .empty(empty), .overflow(overflow),
        .res_count(res_count), .max_val(max_val)
    );

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    // Words accepted by the model, in the order they must leave the FIFO.
    logic [DATA_W-1:0] expQ[$];

    // Model state visible now, and state expected after the coming edge.
    int nowLevel = 0, nowCount = 0, nowMax = 0;
    bit nowOvf = 1'b0;
    int nextLevel = 0, nextCount = 0, nextMax = 0;
    bit nextOvf = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs just after the edge and advance the reference model.
    task automatic applyStimulus(input bit rst, input bit c, input bit ov,
                                 input logic [DATA_W-1:0] d, input bit rr);
        bit doPop, doPush;
        @(posedge clk);
        #1;
        nowLevel = nextLevel;
        nowCount = nextCount;
        nowMax   = nextMax;
        nowOvf   = nextOvf;
        reset     = rst;
        clr       = c;
        out_valid = ov;
        mac_out   = d;
        rd_ready  = rr;
        if (rst || c) begin
            expQ.delete();
            nextLevel = 0;
            nextCount = 0;
            nextMax   = 0;
            nextOvf   = 1'b0;
        end else begin
            doPop  = (nowLevel > 0) && rr;
            doPush = ov && ((nowLevel < DEPTH) || doPop);
            if (doPush) begin
                expQ.push_back(d);
                if (nextCount < (2**CNT_W) - 1) nextCount++;
                if (int'(d) > nextMax) nextMax = int'(d);
            end
            if (ov && !doPush) nextOvf = 1'b1;
            nextLevel = nowLevel + int'(doPush) - int'(doPop);
        end
    endtask

    task automatic idleAndSettle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        #3;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic softClear();
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    endtask

    // Monitor: mid-cycle, compare every output with the model and retire handshakes.
    initial begin
        logic [DATA_W-1:0] head;
        forever begin
            @(negedge clk);
            if (checking) begin
                checkOutput("level", level, nowLevel);
                checkOutput("full", full, (nowLevel == DEPTH));
                checkOutput("empty", empty, (nowLevel == 0));
                checkOutput("rd_valid", rd_valid, (nowLevel > 0));
                checkOutput("overflow", overflow, nowOvf);
                checkOutput("res_count", res_count, nowCount);
                checkOutput("max_val", max_val, nowMax);
                if (nowLevel == 0) checkOutput("rd_data_empty", rd_data, 0);
                if (nowLevel > 0 && rd_ready && !reset && !clr) begin
                    if (expQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL scoreboard_empty: got rd_data=%0d, expected no entry", rd_data);
                    end else begin
                        head = expQ.pop_front();
                        checkOutput("rd_data", rd_data, head);
                    end
                end
            end
        end
    end

    initial begin
        // Reset held for two cycles.
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checking = 1'b1;
        idleAndSettle();
        checkOutput("reset_rd_valid", rd_valid, 0);
        checkOutput("reset_empty", empty, 1);
        checkOutput("reset_rd_data", rd_data, 0);

        // Basic ordering.
        applyStimulus(1'b0, 1'b0, 1'b1, 11'd3, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 11'd17, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 11'd1023, 1'b0);
        idleAndSettle();
        checkOutput("basic_level", level, 3);
        checkOutput("basic_head", rd_data, 3);
        drain(3);
        idleAndSettle();
        checkOutput("basic_count", res_count, 3);
        checkOutput("basic_max", max_val, 1023);
        checkOutput("basic_empty", empty, 1);

        // Fill and overflow.
        softClear();
        for (int i = 1; i <= 9; i++) applyStimulus(1'b0, 1'b0, 1'b1, DATA_W'(i), 1'b0);
        idleAndSettle();
        checkOutput("fill_full", full, 1);
        checkOutput("fill_overflow", overflow, 1);
        checkOutput("fill_count", res_count, 8);
        drain(8);
        idleAndSettle();
        checkOutput("fill_drained", level, 0);

        // Full with simultaneous push and pop.
        softClear();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 1'b1, DATA_W'(100 + i*10), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 11'd500, 1'b1);
        idleAndSettle();
        checkOutput("simul_level", level, 8);
        checkOutput("simul_overflow", overflow, 0);
        checkOutput("simul_head", rd_data, 110);
        drain(8);

        // Streaming wrap-around.
        softClear();
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b1, DATA_W'(i*7), 1'b1);
        idleAndSettle();
        checkOutput("stream_max", max_val, 133);
        checkOutput("stream_level", level, 1);
        drain(1);

        // Mid-operation clear, with push and pop requested in the same cycle.
        softClear();
        for (int i = 1; i <= 9; i++) applyStimulus(1'b0, 1'b0, 1'b1, DATA_W'(i*50), 1'b0);
        drain(3);
        applyStimulus(1'b0, 1'b1, 1'b1, 11'd77, 1'b1);
        idleAndSettle();
        checkOutput("clr_level", level, 0);
        checkOutput("clr_rd_valid", rd_valid, 0);
        checkOutput("clr_overflow", overflow, 0);
        checkOutput("clr_count", res_count, 0);
        checkOutput("clr_max", max_val, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 11'd42, 1'b0);
        idleAndSettle();
        checkOutput("clr_readback", rd_data, 42);
        drain(1);

        // Random traffic with varying consumer pressure.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int rdPct;
            rdPct = ((cyc / 250) % 2 == 0) ? 30 : 80;
            applyStimulus(1'b0,
                          ($urandom_range(0, 599) == 0),
                          ($urandom_range(0, 99) < 60),
                          DATA_W'($urandom_range(0, 2047)),
                          ($urandom_range(0, 99) < rdPct));
        end
        drain(DEPTH + 1);
        idleAndSettle();
        checkOutput("final_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
